// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Multi-cycle subtractor computing diff = a - b - bin over WIDTH bits,
//   DIGIT bits per clock, by iterating one DIGIT-wide borrow-chain slice.
//   A start/busy/done handshake frames each operation. Signed overflow and
//   zero flags are reported with the result.
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_rst_n        synchronous reset, active-low
//   i_start        request, sampled only in IDLE or DONE
//   i_a, i_b       minuend / subtrahend, captured on an accepted start
//   i_bin          borrow-in to bit 0, captured on an accepted start
//   i_signed_mode  1: o_ovf reports two's-complement overflow
//   o_busy         high while an operation is being computed
//   o_done         one-cycle pulse, results valid
//   o_diff         result, held from done until the next completion
//   o_bout         borrow out of the MSB (unsigned a < b + bin)
//   o_ovf          signed overflow, 0 when signed_mode was 0
//   o_zero         o_diff == 0
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  input  logic             i_signed_mode,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  // Reject parameter sets where the digit does not tile the word evenly.
  if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1) begin : g_badParams
    $error("serial_subtractor: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_accept;
  logic             w_lastStep;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic             r_signedMode;
  logic [DIGIT-1:0] w_digitDiff;
  logic             w_borrowOut;
  logic             w_borrowIntoTop;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;

  assign w_lastStep = (r_count == CW'(STEPS - 1));

  // Next-state logic. A start is only honoured when no operation is in
  // flight, so IDLE and DONE both accept it; DONE accepting it is what gives
  // back-to-back operation with no idle cycle in between.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (w_lastStep) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_nextState = RUN;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // One DIGIT-wide ripple-borrow slice. The operand registers are shifted
  // right each step, so the current digit always sits in the low bits. The
  // borrow entering the slice's top bit is kept because on the final step
  // that is the borrow into the word's MSB, needed for signed overflow.
  always_comb begin
    logic br;
    logic x;
    logic y;
    br              = r_borrow;
    w_borrowIntoTop = r_borrow;
    w_digitDiff     = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) begin
        w_borrowIntoTop = br;
      end
      x              = r_a[i];
      y              = r_b[i];
      w_digitDiff[i] = x ^ y ^ br;
      br             = (~x & y) | (~(x ^ y) & br);
    end
    w_borrowOut = br;
  end

  // Result assembly. Finished digits are shifted down from the top of a
  // partial register, so after the last step the new digit on top plus the
  // partial register below it form the complete word. A single-step build
  // has no partial register at all.
  if (DIGIT == WIDTH) begin : g_single
    assign w_result = w_digitDiff;
  end else begin : g_multi
    logic [WIDTH-DIGIT-1:0] r_partial;

    assign w_result = {w_digitDiff, r_partial};

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_partial <= '0;
      end else if (r_state == RUN) begin
        r_partial <= w_result[WIDTH-1:DIGIT];
      end
    end
  end

  // State register and datapath. Operands are captured on an accepted start
  // and never re-sampled; the visible outputs change only on the edge that
  // completes an operation, so they hold the previous result during RUN.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_borrow     <= 1'b0;
      r_signedMode <= 1'b0;
      r_diff       <= '0;
      r_bout       <= 1'b0;
      r_ovf        <= 1'b0;
      r_zero       <= 1'b1;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_a          <= i_a;
        r_b          <= i_b;
        r_borrow     <= i_bin;
        r_signedMode <= i_signed_mode;
        r_count      <= '0;
      end else if (r_state == RUN) begin
        r_a      <= r_a >> DIGIT;
        r_b      <= r_b >> DIGIT;
        r_borrow <= w_borrowOut;
        r_count  <= r_count + CW'(1);
        if (w_lastStep) begin
          r_diff <= w_result;
          r_bout <= w_borrowOut;
          r_ovf  <= r_signedMode & (w_borrowIntoTop ^ w_borrowOut);
          r_zero <= (w_result == '0);
        end
      end
    end
  end

  assign o_busy = (r_state == RUN);
  assign o_done = (r_state == DONE);
  assign o_diff = r_diff;
  assign o_bout = r_bout;
  assign o_ovf  = r_ovf;
  assign o_zero = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor. The main instance uses
//   WIDTH=8/DIGIT=1; two extra instances (DIGIT=4 and DIGIT=8) share the
//   operand inputs but have their own start so they can be exercised alone.
module tb_serial_subtractor;

  localparam int W     = 8;
  localparam int STEPS = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       sm;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
  } vec_t;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
    int         dueCycle;
  } sbItem_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         startAux;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         sm;

  logic         o_busy, o_done, o_bout, o_ovf, o_zero;
  logic [W-1:0] o_diff;
  logic         busy4, done4, bout4, ovf4, zero4;
  logic [W-1:0] diff4;
  logic         busy8, done8, bout8, ovf8, zero8;
  logic [W-1:0] diff8;

  int           cycleCount = 0;
  int           checkCount = 0;
  int           failCount  = 0;
  bit           monitorOn  = 1'b0;
  logic [7:0]   lastExpDiff = 8'h00;
  sbItem_t      sbQueue[$];
  vec_t         vecs[10];

  serial_subtractor #(.WIDTH(W), .DIGIT(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b),
    .i_bin(bin), .i_signed_mode(sm), .o_busy(o_busy), .o_done(o_done),
    .o_diff(o_diff), .o_bout(o_bout), .o_ovf(o_ovf), .o_zero(o_zero)
  );

  serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(startAux), .i_a(a), .i_b(b),
    .i_bin(bin), .i_signed_mode(sm), .o_busy(busy4), .o_done(done4),
    .o_diff(diff4), .o_bout(bout4), .o_ovf(ovf4), .o_zero(zero4)
  );

  serial_subtractor #(.WIDTH(W), .DIGIT(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(startAux), .i_a(a), .i_b(b),
    .i_bin(bin), .i_signed_mode(sm), .o_busy(busy8), .o_done(done8),
    .o_diff(diff8), .o_bout(bout8), .o_ovf(ovf8), .o_zero(zero8)
  );

  // Free-running clock and a cycle counter used to check latency.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  // Reference arithmetic: wide unsigned subtraction for diff/bout and true
  // signed arithmetic for overflow.
  function automatic void refModel(input logic [7:0] ra, input logic [7:0] rb, input logic rbin,
                                   input logic rsm, output logic [7:0] d, output logic bo,
                                   output logic ov, output logic z);
    logic [8:0] full;
    int         s;
    full = {1'b0, ra} - {1'b0, rb} - {8'b0, rbin};
    d    = full[7:0];
    bo   = full[8];
    s    = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
    ov   = rsm && (s < -128 || s > 127);
    z    = (d == 8'h00);
  endfunction

  // The start drives at a negedge, so the accepting edge is one cycle on and
  // done is seen STEPS cycles after that.
  task automatic pushExpected(input logic [7:0] d, input logic bo, input logic ov, input logic z);
    sbItem_t item;
    item.diff     = d;
    item.bout     = bo;
    item.ovf      = ov;
    item.zero     = z;
    item.dueCycle = cycleCount + STEPS + 1;
    sbQueue.push_back(item);
  endtask

  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic vbin,
                               input logic vsm, input logic [7:0] d, input logic bo,
                               input logic ov, input logic z);
    @(negedge clk);
    a     = va;
    b     = vb;
    bin   = vbin;
    sm    = vsm;
    start = 1'b1;
    pushExpected(d, bo, ov, z);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sbQueue.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sbQueue.size() != 0) begin
      checkOutput("done_timeout", sbQueue.size(), 0);
      sbQueue.delete();
    end
    @(negedge clk);
  endtask

  // Exercise the DIGIT=8 and DIGIT=4 builds together on one vector: their
  // done pulses must land one and two compute cycles after the start edge.
  task automatic runAux(input logic [7:0] va, input logic [7:0] vb, input logic vbin, input logic vsm);
    logic [7:0] d;
    logic       bo, ov, z;
    refModel(va, vb, vbin, vsm, d, bo, ov, z);
    @(negedge clk);
    a        = va;
    b        = vb;
    bin      = vbin;
    sm       = vsm;
    startAux = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      startAux = 1'b0;
      checkOutput("d8_done_timing", done8, (k == 2));
      checkOutput("d4_done_timing", done4, (k == 3));
      if (k == 2) begin
        checkOutput("d8_diff", diff8, d);
        checkOutput("d8_bout", bout8, bo);
        checkOutput("d8_ovf", ovf8, ov);
        checkOutput("d8_zero", zero8, z);
      end
      if (k == 3) begin
        checkOutput("d4_diff", diff4, d);
        checkOutput("d4_bout", bout4, bo);
        checkOutput("d4_ovf", ovf4, ov);
        checkOutput("d4_zero", zero4, z);
      end
    end
  endtask

  // Scoreboard monitor for the main instance: every done pops one expected
  // result; a done with nothing outstanding is itself an error.
  always @(negedge clk) begin
    sbItem_t item;
    if (monitorOn) begin
      checkOutput("busy_done_exclusive", {31'b0, o_busy & o_done}, 0);
      if (o_done) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected_done", o_done, 0);
        end else begin
          item = sbQueue.pop_front();
          checkOutput("diff", o_diff, item.diff);
          checkOutput("bout", o_bout, item.bout);
          checkOutput("ovf", o_ovf, item.ovf);
          checkOutput("zero", o_zero, item.zero);
          checkOutput("latency", cycleCount, item.dueCycle);
          lastExpDiff = item.diff;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       rbo, rov, rz;
    logic [7:0] ra, rb;
    logic       rbin, rsm;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{8'h80, 8'h00, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    startAux = 1'b0;
    a        = '0;
    b        = '0;
    bin      = 1'b0;
    sm       = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_diff", o_diff, 0);
    checkOutput("rst_bout", o_bout, 0);
    checkOutput("rst_ovf", o_ovf, 0);
    checkOutput("rst_zero", o_zero, 1);
    rst_n     = 1'b1;
    monitorOn = 1'b1;
    @(negedge clk);

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].sm,
                    vecs[i].diff, vecs[i].bout, vecs[i].ovf, vecs[i].zero);
      waitDrain();
    end

    // Start during RUN is ignored and the old result is held meanwhile.
    applyStimulus(8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("run_busy", o_busy, 1);
    checkOutput("run_diff_held", o_diff, lastExpDiff);
    a     = 8'hFF;
    b     = 8'h00;
    bin   = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    waitDrain();
    repeat (12) @(negedge clk);
    checkOutput("idle_after_ignored_start", o_busy, 0);

    // Start held high through DONE: the next operation follows immediately.
    @(negedge clk);
    a     = 8'h80;
    b     = 8'h01;
    bin   = 1'b0;
    sm    = 1'b1;
    start = 1'b1;
    pushExpected(8'h7F, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_done) break;
    end
    checkOutput("b2b_first_done", o_done, 1);
    a = 8'h7F;
    b = 8'hFF;
    pushExpected(8'h80, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_busy_no_gap", o_busy, 1);
    waitDrain();

    // Reset in the middle of an operation discards it.
    @(negedge clk);
    a     = 8'h33;
    b     = 8'h11;
    bin   = 1'b0;
    sm    = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrst_busy", o_busy, 0);
    checkOutput("midrst_done", o_done, 0);
    checkOutput("midrst_diff", o_diff, 0);
    checkOutput("midrst_zero", o_zero, 1);
    checkOutput("midrst_bout", o_bout, 0);
    checkOutput("midrst_ovf", o_ovf, 0);
    repeat (12) @(negedge clk);
    applyStimulus(8'h33, 8'h11, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
    waitDrain();

    // Random sweep against the reference model.
    for (int i = 0; i < 150; i++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      rsm  = 1'($urandom_range(0, 1));
      refModel(ra, rb, rbin, rsm, rd, rbo, rov, rz);
      applyStimulus(ra, rb, rbin, rsm, rd, rbo, rov, rz);
      waitDrain();
    end

    // Wider-digit builds: spec vectors plus a random batch.
    runAux(8'h05, 8'h03, 1'b0, 1'b0);
    runAux(8'h80, 8'h01, 1'b0, 1'b1);
    runAux(8'h7F, 8'hFF, 1'b0, 1'b1);
    runAux(8'h10, 8'h0F, 1'b1, 1'b0);
    runAux(8'h00, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      runAux(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
